// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared encodings for the V3023 RTC bus arbiter: FSM states, control-bit
// positions, idle bus value and one-hot grant codes.
package rtc_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int CTL_AD = 3;
    localparam int CTL_CS = 2;
    localparam int CTL_RD = 1;
    localparam int CTL_WR = 0;

    localparam logic [3:0] CTL_IDLE  = 4'b1111;
    localparam logic [7:0] DOUT_IDLE = 8'h00;

    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_INI  = 3'b001;
    localparam logic [2:0] GNT_PRG  = 3'b010;
    localparam logic [2:0] GNT_LEE  = 3'b100;

    localparam logic LAST_PRG = 1'b0;
    localparam logic LAST_LEE = 1'b1;

endpackage

// File: rtl/rtc_wdt_counter.sv
// Up-counter with clear, load and terminal-count compare; used both as the
// inter-session gap timer and as the session watchdog.
module rtc_wdt_counter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic [WIDTH-1:0] tc_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Counter register: clear beats load beats increment.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (enable) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == tc_val);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbiter sharing the V3023 RTC parallel bus between the init, programming
// and periodic-read sequencers, with turnaround gap and session watchdog.
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4095
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ini_req,
    input  logic       prg_req,
    input  logic       lee_req,
    input  logic [3:0] ini_ctl,
    input  logic [3:0] prg_ctl,
    input  logic [3:0] lee_ctl,
    input  logic [7:0] ini_dout,
    input  logic [7:0] prg_dout,
    input  logic [7:0] lee_dout,
    input  logic       ini_oe,
    input  logic       prg_oe,
    input  logic       lee_oe,
    output logic [3:0] rtc_ctl,
    output logic [7:0] rtc_dout,
    output logic       rtc_oe,
    output logic [2:0] grant,
    output logic       busy,
    output logic       init_ok,
    output logic       tmo_err,
    input  logic       err_clr
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic [2:0] grant_r;
    logic [2:0] grant_nxt_s;
    logic [2:0] mask_r;
    logic       last_srv_r;
    logic       init_ok_r;
    logic       tmo_err_r;

    logic [2:0] req_s;
    logic [2:0] elig_s;
    logic [2:0] pick_s;
    logic       gnt_req_s;
    logic       rel_norm_s;
    logic       rel_force_s;
    logic       wdt_tc_s;
    logic       gap_tc_s;

    assign req_s  = {lee_req, prg_req, ini_req};
    // Until init completes only the init sequencer may own the bus.
    assign elig_s = req_s & ~mask_r & {init_ok_r, init_ok_r, 1'b1};

    assign gnt_req_s   = |(grant_r & req_s);
    assign rel_norm_s  = (state_r == ST_GRANT) && !gnt_req_s;
    assign rel_force_s = (state_r == ST_GRANT) && gnt_req_s && wdt_tc_s;

    // Winner selection: init first, then alternate prg/lee on a tie.
    always_comb begin
        pick_s = GNT_NONE;
        if (elig_s[0]) begin
            pick_s = GNT_INI;
        end else if (elig_s[1] && elig_s[2]) begin
            pick_s = (last_srv_r == LAST_LEE) ? GNT_PRG : GNT_LEE;
        end else if (elig_s[1]) begin
            pick_s = GNT_PRG;
        end else if (elig_s[2]) begin
            pick_s = GNT_LEE;
        end else begin
            pick_s = GNT_NONE;
        end
    end

    // Next-state and next-grant logic.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s != GNT_NONE) begin
                    state_nxt_s = ST_GRANT;
                    grant_nxt_s = pick_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = GNT_NONE;
                end
            end
            ST_GRANT: begin
                if (rel_norm_s || rel_force_s) begin
                    state_nxt_s = ST_GAP;
                    grant_nxt_s = GNT_NONE;
                end else begin
                    state_nxt_s = ST_GRANT;
                    grant_nxt_s = grant_r;
                end
            end
            ST_GAP: begin
                grant_nxt_s = GNT_NONE;
                if (gap_tc_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = GNT_NONE;
            end
        endcase
    end

    // FSM state and grant registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            grant_r <= GNT_NONE;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Masks, fairness bit and sticky status flags; timeout set beats err_clr.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mask_r     <= 3'b000;
            last_srv_r <= LAST_LEE;
            init_ok_r  <= 1'b0;
            tmo_err_r  <= 1'b0;
        end else begin
            mask_r <= (mask_r & req_s) | (rel_force_s ? grant_r : 3'b000);
            if ((rel_norm_s || rel_force_s) && (grant_r == GNT_PRG)) begin
                last_srv_r <= LAST_PRG;
            end else if ((rel_norm_s || rel_force_s) && (grant_r == GNT_LEE)) begin
                last_srv_r <= LAST_LEE;
            end else begin
                last_srv_r <= last_srv_r;
            end
            if (rel_norm_s && (grant_r == GNT_INI)) begin
                init_ok_r <= 1'b1;
            end else begin
                init_ok_r <= init_ok_r;
            end
            if (rel_force_s) begin
                tmo_err_r <= 1'b1;
            end else if (err_clr) begin
                tmo_err_r <= 1'b0;
            end else begin
                tmo_err_r <= tmo_err_r;
            end
        end
    end

    rtc_wdt_counter #(.WIDTH(12)) u_gap_cnt (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (state_r == ST_IDLE),
        .load     (rel_norm_s || rel_force_s),
        .load_val (12'd1),
        .enable   (state_r == ST_GAP),
        .tc_val   (12'(GAP_CYCLES)),
        .tc       (gap_tc_s)
    );

    rtc_wdt_counter #(.WIDTH(12)) u_wdt_cnt (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (state_r == ST_GAP),
        .load     ((state_r == ST_IDLE) && (pick_s != GNT_NONE)),
        .load_val (12'd1),
        .enable   (state_r == ST_GRANT),
        .tc_val   (12'(TIMEOUT)),
        .tc       (wdt_tc_s)
    );

    // Pad mux: only the registered grant selects a source, so a
    // non-granted requester can never reach the pads.
    always_comb begin
        rtc_ctl  = CTL_IDLE;
        rtc_dout = DOUT_IDLE;
        rtc_oe   = 1'b0;
        case (grant_r)
            GNT_INI: begin
                rtc_ctl  = ini_ctl;
                rtc_dout = ini_dout;
                rtc_oe   = ini_oe;
            end
            GNT_PRG: begin
                rtc_ctl  = prg_ctl;
                rtc_dout = prg_dout;
                rtc_oe   = prg_oe;
            end
            GNT_LEE: begin
                rtc_ctl  = lee_ctl;
                rtc_dout = lee_dout;
                rtc_oe   = lee_oe;
            end
            default: begin
                rtc_ctl  = CTL_IDLE;
                rtc_dout = DOUT_IDLE;
                rtc_oe   = 1'b0;
            end
        endcase
    end

    assign grant   = grant_r;
    assign busy    = (state_r != ST_IDLE);
    assign init_ok = init_ok_r;
    assign tmo_err = tmo_err_r;

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Shares the single V3023 RTC parallel bus (A/D, CS, RD, WR, 8-bit data) among three bus sequencers: the initialization sequencer, the user programming (write) sequencer and the periodic read sequencer. It enforces init-first ordering, alternates fairly between programming and reading, inserts a turnaround gap between sessions, and breaks hung sessions with a watchdog. It sits between the sequencers and the RTC pad drivers.

## Interface
- GAP_CYCLES, 2, idle bus cycles inserted after every session (1..15)
- TIMEOUT, 4095, maximum cycles a session may hold the bus (12-bit counter)
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- ini_req / prg_req / lee_req  in  1 each  session request; held high by the requester for its whole session, across all its transfers
- ini_ctl / prg_ctl / lee_ctl  in  4 each  requester bus controls {AD, CS, RD, WR}, active-low
- ini_dout / prg_dout / lee_dout  in  8 each  requester write data
- ini_oe / prg_oe / lee_oe  in  1 each  requester data-drive enable
- rtc_ctl  out  4  muxed {AD, CS, RD, WR} to pads
- rtc_dout  out  8  muxed write data
- rtc_oe  out  1  muxed drive enable
- grant  out  3  one-hot {lee, prg, ini}
- busy  out  1  high in GRANT or GAP
- init_ok  out  1  sticky: one init session completed normally
- tmo_err  out  1  sticky watchdog flag
- err_clr  in  1  synchronous clear of tmo_err

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: choose an eligible requester; go to GRANT with grant register loaded; else stay.
- Eligibility: req high and not masked. Before init_ok, only ini is eligible.
- Priority: ini above all. Among prg and lee: if only one is eligible, it wins; if both, the one not served last wins (last_srv bit, reset to lee so prg wins the first tie).
- GRANT: bus outputs follow the granted requester combinationally. Leave on the cycle the granted req is seen low (normal release) or when the watchdog reaches TIMEOUT (forced release). Either exit goes to GAP, loads gap counter, updates last_srv (prg/lee only).
- Normal release of ini sets init_ok. A forced release does not set init_ok.
- Forced release: sets tmo_err, sets the mask bit of that requester. A mask bit clears when its req is seen low.
- GAP: bus idle; count GAP_CYCLES cycles, then IDLE.
- Bus idle value (IDLE, GAP, reset): rtc_ctl = 4'b1111, rtc_dout = 8'h00, rtc_oe = 0.
- A non-granted requester's inputs never reach the pads.
- err_clr clears tmo_err. If a timeout occurs in the same cycle, set wins.
- Reset values: state IDLE, grant 000, busy 0, init_ok 0, tmo_err 0, masks 0, last_srv lee, counters 0, bus idle.

## Timing
- Request seen high in IDLE at cycle N: grant and bus mux are valid at N+1.
- Granted req seen low at cycle M: grant = 000 and bus idle at M+1. GAP covers M+1..M+GAP_CYCLES, and state is IDLE at M+GAP_CYCLES+1. The earliest next grant is M+GAP_CYCLES+2.
- Watchdog counts grant cycles from 1. At count TIMEOUT, the next cycle is GAP.
- Req drop and timeout in the same cycle: treated as a normal release, with no error and no mask.
- Requests raised during GRANT or GAP wait. Requests dropped before being granted are never served.
- Reset asserted mid-session: all outputs reach reset values asynchronously, without waiting for a clock edge.

## Structure
- The shared header holds the state encodings, the ctl bit indices (AD=3, CS=2, RD=1, WR=0), the CTL_IDLE constant 4'b1111, and the grant one-hot encodings.
- Sub-module rtc_wdt_counter: 12-bit load, clear and terminal-count counter. It is instantiated twice, once as the gap counter and once as the watchdog.
- Arbitration, masks, sticky flags and the output mux stay in the top module.

## Test plan
- Reset, then prg_req = lee_req = 1 with ini_req = 0 -> grant stays 000 and rtc_ctl = 4'hF indefinitely. Then raise ini_req -> grant = 001 one cycle later.
- ini session with ini_ctl = 4'b0101 and ini_dout = 8'h02, ini_req dropped at M -> pads show 4'b0101/8'h02 while granted, idle at M+1, init_ok = 1 at M+1, grant 000 until at least M+4 (GAP_CYCLES = 2).
- After init_ok, prg_req and lee_req high together for three back-to-back sessions -> grants occur in the order prg, lee, prg.
- With TIMEOUT = 16, hold lee_req high -> grant released after 16 cycles, tmo_err = 1, lee not re-granted until lee_req drops and rises again. Pulse err_clr -> tmo_err = 0.
- Drive a non-granted requester's ctl to 4'b0000 during a prg session -> pads carry only prg values.
- Assert Reset mid-session -> rtc_ctl = 4'hF, grant = 000 and init_ok = 0 before the next Clock edge.
